// File: rtl/mod_counter_ctrl.sv
// ============================================================================
//  Module   : mod_counter_ctrl
//  Brief    : Start/stop/pause sequencer for a programmable-modulus up-counter
//             with terminal-count strobe, wrap counting and run-length done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_counter_ctrl #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          cllk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [W-1:0]  mod_val,
  input  logic [CW-1:0] cycles,
  output logic [W-1:0]  count,
  output logic          tc,
  output logic [CW-1:0] wraps,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [W-1:0]  C_MIN_MOD  = W'(2);
  localparam logic [W-1:0]  C_CNT_ONE  = W'(1);
  localparam logic [CW-1:0] C_WRAP_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_count;
  logic [W-1:0]  r_mod;
  logic [CW-1:0] r_wraps;
  logic [CW-1:0] r_target;
  logic          r_tc;
  logic          r_done;
  logic          r_err;

  logic          w_last;
  logic [CW-1:0] w_wraps_next;

  assign w_last = (r_count == (r_mod - C_CNT_ONE));
  // Saturate so an unbounded run never rolls the wrap count back to zero.
  assign w_wraps_next = (r_wraps == '1) ? r_wraps : (r_wraps + C_WRAP_ONE);

  always_ff @(posedge cllk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_mod    <= '0;
      r_wraps  <= '0;
      r_target <= '0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tc   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (mod_val >= C_MIN_MOD) begin
              r_mod    <= mod_val;
              r_target <= cycles;
              r_count  <= '0;
              r_wraps  <= '0;
              r_state  <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (pause) begin
            r_state <= S_HOLD;
          end else if (w_last) begin
            r_count <= '0;
            r_tc    <= 1'b1;
            r_wraps <= w_wraps_next;
            if ((r_target != '0) && (w_wraps_next == r_target)) begin
              r_state <= S_DONE;
            end
          end else begin
            r_count <= r_count + C_CNT_ONE;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (!pause) begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign wraps = r_wraps;
  assign tc    = r_tc;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_ctrl.sv
// ============================================================================
//  Module   : tb_mod_counter_ctrl
//  Brief    : Directed self-checking bench for mod_counter_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_counter_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          cllk = 1'b0;
  logic          reset, start, stop, pause;
  logic [W-1:0]  mod_val;
  logic [CW-1:0] cycles;
  logic [W-1:0]  count;
  logic          tc, busy, done, err;
  logic [CW-1:0] wraps;

  int passed = 0;
  int total  = 0;

  mod_counter_ctrl #(.W(W), .CW(CW)) dut (
    .cllk(cllk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mod_val(mod_val), .cycles(cycles), .count(count), .tc(tc),
    .wraps(wraps), .busy(busy), .done(done), .err(err)
  );

  always #5 cllk = ~cllk;

  // Advance one rising edge and settle; inputs changed here apply at the next edge.
  task automatic step();
    @(posedge cllk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic kick(input int m, input int c);
    mod_val = W'(m); cycles = CW'(c); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step();
    chk("rst_count", int'(count), 0);
    chk("rst_wraps", int'(wraps), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({tc, done, err}), 0);
    reset = 1'b0;
    kick(12, 0);
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_count", int'(count), 5);
    reset = 1'b1; step();
    chk("midrst_count", int'(count), 0);
    step();
    reset = 1'b0; step();
    chk("midrst_count2", int'(count), 0);
    chk("midrst_wraps", int'(wraps), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulses", int'({tc, done}), 0);
  endtask

  task automatic test_mod12();
    kick(12, 2);
    chk("m12_start_count", int'(count), 0);
    chk("m12_start_busy", int'(busy), 1);
    for (int i = 1; i <= 24; i++) begin
      step();
      chk($sformatf("m12_count_%0d", i), int'(count), i % 12);
      chk($sformatf("m12_tc_%0d", i), int'(tc), (i % 12 == 0) ? 1 : 0);
      chk($sformatf("m12_wraps_%0d", i), int'(wraps), i / 12);
      chk($sformatf("m12_busy_%0d", i), int'(busy), (i < 24) ? 1 : 0);
      chk($sformatf("m12_done_%0d", i), int'(done), 0);
    end
    step();
    chk("m12_done", int'(done), 1);
    chk("m12_done_busy", int'(busy), 0);
    chk("m12_done_wraps", int'(wraps), 2);
    chk("m12_done_tc", int'(tc), 0);
    step();
    chk("m12_done_pulse_width", int'(done), 0);
  endtask

  task automatic test_pause();
    kick(12, 0);
    for (int i = 0; i < 7; i++) step();
    chk("pause_pre_count", int'(count), 7);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pause_hold_count_%0d", i), int'(count), 7);
      chk($sformatf("pause_hold_tc_%0d", i), int'(tc), 0);
      chk($sformatf("pause_hold_busy_%0d", i), int'(busy), 1);
    end
    pause = 1'b0;
    step();
    chk("pause_resume_count0", int'(count), 7);
    step();
    chk("pause_resume_count1", int'(count), 8);
    step();
    chk("pause_resume_count2", int'(count), 9);
    stop = 1'b1; step(); stop = 1'b0;
    chk("pause_stop_busy", int'(busy), 0);
    chk("pause_stop_count", int'(count), 9);
  endtask

  task automatic test_stop_wrap();
    kick(5, 0);
    for (int i = 0; i < 4; i++) step();
    chk("sw_pre_count", int'(count), 4);
    stop = 1'b1; step(); stop = 1'b0;
    chk("sw_count", int'(count), 4);
    chk("sw_tc", int'(tc), 0);
    chk("sw_wraps", int'(wraps), 0);
    chk("sw_busy", int'(busy), 0);
    chk("sw_done", int'(done), 0);
    step();
    chk("sw_idle_count", int'(count), 4);
    chk("sw_idle_done", int'(done), 0);
  endtask

  task automatic test_bad_mod();
    kick(1, 3);
    chk("bad1_err", int'(err), 1);
    chk("bad1_busy", int'(busy), 0);
    chk("bad1_count", int'(count), 4);
    step();
    chk("bad1_err_width", int'(err), 0);
    kick(0, 3);
    chk("bad0_err", int'(err), 1);
    chk("bad0_busy", int'(busy), 0);
    step();
    chk("bad0_err_width", int'(err), 0);
    chk("bad0_count", int'(count), 4);
  endtask

  task automatic test_config_isolation();
    kick(3, 1);
    chk("cfg_count0", int'(count), 0);
    mod_val = 4'd9; cycles = 8'd7; start = 1'b1;
    step();
    chk("cfg_count1", int'(count), 1);
    chk("cfg_run_err", int'(err), 0);
    step();
    chk("cfg_count2", int'(count), 2);
    start = 1'b0;
    step();
    chk("cfg_wrap_count", int'(count), 0);
    chk("cfg_wrap_tc", int'(tc), 1);
    chk("cfg_wrap_wraps", int'(wraps), 1);
    chk("cfg_wrap_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_done", int'(done), 1);
    chk("cfg_done_start_ignored", int'(busy), 0);
    chk("cfg_done_err", int'(err), 0);
    step();
    chk("cfg_after_busy", int'(busy), 0);
    chk("cfg_after_count", int'(count), 0);
  endtask

  task automatic test_back_to_back();
    kick(2, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("m2_count_%0d", i), int'(count), i % 2);
      chk($sformatf("m2_tc_%0d", i), int'(tc), (i % 2 == 0) ? 1 : 0);
    end
    chk("m2_wraps", int'(wraps), 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("m2_stop_busy", int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mod_val = '0; cycles = '0;
    test_reset();
    test_mod12();
    test_pause();
    test_stop_wrap();
    test_bad_mod();
    test_config_isolation();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
